combo_lock_checker: RTL and testbench

- Consumer side of the digit selector: accepts digits confirmed by a debounced enter pulse and accumulates them into an entry sequence.
- Compares the entered sequence against a stored code and drives lock status.
- Provides four display nibbles for the seven-segment driver, so the entered digits are shown as they are keyed.
- Sits between the debouncers/up-down selector and the display driver in the combo-lock top level.

---
 rtl/combo_lock_checker_if.sv | 24 ++
 rtl/combo_lock_checker.sv | 157 +++++++++++++++
 tb/tb_combo_lock_checker.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/combo_lock_checker_if.sv
// Signal bundle between the digit selector/debouncers, the lock checker and the display driver.
interface combo_lock_checker_if;
  logic [3:0] digit_in;
  logic       enter;
  logic       clear;
  logic       unlocked;
  logic       alarm;
  logic [3:0] fail_count;
  logic [2:0] entry_count;
  logic [3:0] disp3;
  logic [3:0] disp2;
  logic [3:0] disp1;
  logic [3:0] disp0;

  modport master (
    output digit_in, enter, clear,
    input  unlocked, alarm, fail_count, entry_count, disp3, disp2, disp1, disp0
  );

  modport slave (
    input  digit_in, enter, clear,
    output unlocked, alarm, fail_count, entry_count, disp3, disp2, disp1, disp0
  );
endinterface

// File: rtl/combo_lock_checker.sv
// Combination-lock checker: collects entered digits, compares them with CODE, handles lockout.
// Optional macro COMBO_LOCK_AUTO_RELOCK_EN adds an OPEN-state relock timeout.
module combo_lock_checker #(
  parameter int unsigned CODE_LEN       = 4,
  parameter logic [15:0] CODE           = 16'h1234,
  parameter int unsigned MAX_FAILS      = 3,
  parameter int unsigned LOCKOUT_CYCLES = 100000000,
  parameter int unsigned RELOCK_CYCLES  = 500000000
) (
  input logic                 clk,
  input logic                 rst,
  combo_lock_checker_if.slave bus
);

  localparam int unsigned CodeW     = 4 * CODE_LEN;
  localparam logic [2:0]  LastCount = 3'(CODE_LEN);
  localparam logic [3:0]  FailLimit = 4'(MAX_FAILS);
  localparam int unsigned LockW     = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam logic [LockW-1:0] LockLast = LockW'(LOCKOUT_CYCLES - 1);

  if (CODE_LEN < 1 || CODE_LEN > 4 || MAX_FAILS < 1 || MAX_FAILS > 15 ||
      LOCKOUT_CYCLES < 1 || RELOCK_CYCLES < 1) begin : genBadParams
    $error("combo_lock_checker: illegal parameter value");
  end

  typedef enum logic [2:0] {StEntry, StCheck, StOpen, StFail, StLockout} stateE;

  stateE            stateQ, stateD;
  logic [15:0]      dispQ, dispD;
  logic [2:0]       entryCountQ, entryCountD;
  logic [3:0]       failCountQ, failCountD;
  logic             unlockedQ, unlockedD;
  logic             alarmQ, alarmD;
  logic [LockW-1:0] lockTimerQ, lockTimerD;
  logic             codeMatch;

`ifdef COMBO_LOCK_AUTO_RELOCK_EN
  localparam int unsigned RelockW = (RELOCK_CYCLES > 1) ? $clog2(RELOCK_CYCLES) : 1;
  localparam logic [RelockW-1:0] RelockLast = RelockW'(RELOCK_CYCLES - 1);
  logic [RelockW-1:0] relockTimerQ, relockTimerD;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) relockTimerQ <= '0;
    else     relockTimerQ <= relockTimerD;
  end
`endif

  // Only the newest CODE_LEN digits take part in the comparison.
  assign codeMatch = (dispQ[CodeW-1:0] == CODE[15 -: CodeW]);

  always_comb begin
    stateD      = stateQ;
    dispD       = dispQ;
    entryCountD = entryCountQ;
    failCountD  = failCountQ;
    unlockedD   = unlockedQ;
    alarmD      = alarmQ;
    lockTimerD  = lockTimerQ;
`ifdef COMBO_LOCK_AUTO_RELOCK_EN
    relockTimerD = relockTimerQ;
`endif
    unique case (stateQ)
      StEntry: begin
        if (bus.clear) begin
          dispD       = '0;
          entryCountD = '0;
        end else if (bus.enter) begin
          dispD       = {dispQ[11:0], bus.digit_in};
          entryCountD = entryCountQ + 3'd1;
          if (entryCountD == LastCount) stateD = StCheck;
        end
      end
      StCheck: begin
        if (codeMatch) begin
          stateD     = StOpen;
          failCountD = '0;
          unlockedD  = 1'b1;
`ifdef COMBO_LOCK_AUTO_RELOCK_EN
          relockTimerD = '0;
`endif
        end else begin
          stateD = StFail;
          if (failCountQ != 4'hF) failCountD = failCountQ + 4'd1;
        end
      end
      StFail: begin
        dispD       = '0;
        entryCountD = '0;
        if (failCountQ >= FailLimit) begin
          stateD     = StLockout;
          alarmD     = 1'b1;
          lockTimerD = '0;
        end else begin
          stateD = StEntry;
        end
      end
      StLockout: begin
        if (lockTimerQ == LockLast) begin
          stateD     = StEntry;
          alarmD     = 1'b0;
          failCountD = '0;
          lockTimerD = '0;
        end else begin
          lockTimerD = lockTimerQ + 1'b1;
        end
      end
      StOpen: begin
        if (bus.clear) begin
          stateD      = StEntry;
          unlockedD   = 1'b0;
          dispD       = '0;
          entryCountD = '0;
`ifdef COMBO_LOCK_AUTO_RELOCK_EN
        end else if (relockTimerQ == RelockLast) begin
          stateD      = StEntry;
          unlockedD   = 1'b0;
          dispD       = '0;
          entryCountD = '0;
        end else begin
          relockTimerD = relockTimerQ + 1'b1;
`endif
        end
      end
      default: stateD = StEntry;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ      <= StEntry;
      dispQ       <= '0;
      entryCountQ <= '0;
      failCountQ  <= '0;
      unlockedQ   <= 1'b0;
      alarmQ      <= 1'b0;
      lockTimerQ  <= '0;
    end else begin
      stateQ      <= stateD;
      dispQ       <= dispD;
      entryCountQ <= entryCountD;
      failCountQ  <= failCountD;
      unlockedQ   <= unlockedD;
      alarmQ      <= alarmD;
      lockTimerQ  <= lockTimerD;
    end
  end

  assign bus.unlocked    = unlockedQ;
  assign bus.alarm       = alarmQ;
  assign bus.fail_count  = failCountQ;
  assign bus.entry_count = entryCountQ;
  assign bus.disp3       = dispQ[15:12];
  assign bus.disp2       = dispQ[11:8];
  assign bus.disp1       = dispQ[7:4];
  assign bus.disp0       = dispQ[3:0];

endmodule

// File: tb/tb_combo_lock_checker.sv
// Directed self-checking bench for combo_lock_checker (short lockout/relock timers).
module tb_combo_lock_checker;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  combo_lock_checker_if bus ();

  combo_lock_checker #(
    .CODE_LEN      (4),
    .CODE          (16'h1234),
    .MAX_FAILS     (3),
    .LOCKOUT_CYCLES(20),
    .RELOCK_CYCLES (10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] dispAll();
    return {bus.disp3, bus.disp2, bus.disp1, bus.disp0};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the following posedge samples the pulse.
  task automatic key(input logic [3:0] d);
    bus.digit_in = d;
    bus.enter    = 1'b1;
    @(negedge clk);
    bus.enter    = 1'b0;
  endtask

  task automatic pulseClear();
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wrongAttempt();
    key(4'd1); key(4'd1); key(4'd1); key(4'd1);
    idle(2);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tests = 0;
    fails = 0;
    rst          = 1'b1;
    bus.digit_in = 4'd0;
    bus.enter    = 1'b0;
    bus.clear    = 1'b0;
    idle(2);
    check("rst_unlocked", 16'(bus.unlocked), 16'h0);
    check("rst_alarm", 16'(bus.alarm), 16'h0);
    check("rst_fail_count", 16'(bus.fail_count), 16'h0);
    check("rst_entry_count", 16'(bus.entry_count), 16'h0);
    check("rst_disp", dispAll(), 16'h0000);
    rst = 1'b0;

    // Correct code
    key(4'd1);
    check("ok_entry1", 16'(bus.entry_count), 16'd1);
    key(4'd2); key(4'd3); key(4'd4);
    check("ok_disp", dispAll(), 16'h1234);
    check("ok_entry4", 16'(bus.entry_count), 16'd4);
    check("ok_unlock_1cyc", 16'(bus.unlocked), 16'h0);
    idle(1);
    check("ok_unlock_2cyc", 16'(bus.unlocked), 16'h1);
    check("ok_fail_count", 16'(bus.fail_count), 16'h0);
    key(4'd5);
    check("open_enter_ignored", dispAll(), 16'h1234);
    idle(1);
    pulseClear();
    check("open_clear_unlocked", 16'(bus.unlocked), 16'h0);
    check("open_clear_disp", dispAll(), 16'h0000);
    check("open_clear_entry", 16'(bus.entry_count), 16'h0);

    // Relock timer: OPEN lasts exactly RELOCK_CYCLES edges without clear
    key(4'd1); key(4'd2); key(4'd3); key(4'd4);
    idle(1);
    check("relock_open", 16'(bus.unlocked), 16'h1);
    idle(9);
    check("relock_before", 16'(bus.unlocked), 16'h1);
    idle(1);
`ifdef COMBO_LOCK_AUTO_RELOCK_EN
    check("relock_expired", 16'(bus.unlocked), 16'h0);
    check("relock_disp", dispAll(), 16'h0000);
`else
    idle(10);
    check("open_persists", 16'(bus.unlocked), 16'h1);
    pulseClear();
    check("open_clear2", 16'(bus.unlocked), 16'h0);
`endif

    // Wrong code
    key(4'd1); key(4'd2); key(4'd3); key(4'd5);
    check("bad_disp", dispAll(), 16'h1235);
    idle(1);
    check("bad_fail_count", 16'(bus.fail_count), 16'd1);
    check("bad_unlocked", 16'(bus.unlocked), 16'h0);
    idle(1);
    check("bad_disp_cleared", dispAll(), 16'h0000);
    check("bad_entry_cleared", 16'(bus.entry_count), 16'h0);
    check("bad_no_alarm", 16'(bus.alarm), 16'h0);

    // Clear in ENTRY and clear+enter collision
    key(4'd1); key(4'd2);
    check("clr_partial", dispAll(), 16'h0012);
    pulseClear();
    check("clr_entry", 16'(bus.entry_count), 16'h0);
    check("clr_disp", dispAll(), 16'h0000);
    check("clr_keeps_fails", 16'(bus.fail_count), 16'd1);
    bus.clear = 1'b1;
    key(4'd7);
    bus.clear = 1'b0;
    check("clr_enter_disp", dispAll(), 16'h0000);
    check("clr_enter_count", 16'(bus.entry_count), 16'h0);
    key(4'd9);
    check("after_clr_key", dispAll(), 16'h0009);
    pulseClear();

    // Lockout after the 3rd consecutive failure
    key(4'd5); key(4'd5); key(4'd5); key(4'd5);
    idle(2);
    check("lk_fail2", 16'(bus.fail_count), 16'd2);
    key(4'd6); key(4'd6); key(4'd6); key(4'd6);
    idle(1);
    check("lk_fail3", 16'(bus.fail_count), 16'd3);
    check("lk_alarm_pre", 16'(bus.alarm), 16'h0);
    idle(1);
    check("lk_alarm_on", 16'(bus.alarm), 16'h1);
    key(4'd3);
    check("lk_enter_ignored", 16'(bus.entry_count), 16'h0);
    pulseClear();
    check("lk_clear_ignored", 16'(bus.alarm), 16'h1);
    idle(17);
    check("lk_alarm_cycle20", 16'(bus.alarm), 16'h1);
    check("lk_fail_held", 16'(bus.fail_count), 16'd3);
    idle(1);
    check("lk_alarm_off", 16'(bus.alarm), 16'h0);
    check("lk_fail_reset", 16'(bus.fail_count), 16'h0);
    check("lk_entry", 16'(bus.entry_count), 16'h0);

    // Asynchronous reset in the middle of a lockout
    wrongAttempt(); wrongAttempt(); wrongAttempt();
    check("ar_alarm_on", 16'(bus.alarm), 16'h1);
    idle(3);
    #2;
    rst = 1'b1;
    #1;
    check("ar_alarm", 16'(bus.alarm), 16'h0);
    check("ar_fail_count", 16'(bus.fail_count), 16'h0);
    check("ar_entry", 16'(bus.entry_count), 16'h0);
    check("ar_unlocked", 16'(bus.unlocked), 16'h0);
    @(negedge clk);
    rst = 1'b0;
    key(4'd1); key(4'd2); key(4'd3); key(4'd4);
    idle(1);
    check("ar_then_unlock", 16'(bus.unlocked), 16'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
